// File: rtl/hyper_lsab_dram_q_if.sv
`default_nettype none
// ============================================================================
// Module   : hyper_lsab_dram_q_if
// Purpose  : Bundles every bus signal of the LSAB <-> DRAM command queue:
//            the command/result port, the block mover command/status port
//            and the MCU page-align handshake.
// Modports : slave  - seen by the queue (hyper_lsab_dram_q)
//            master - seen by the surrounding system / testbench
// Revision : 1.0 - initial release
// ============================================================================
interface hyper_lsab_dram_q_if #(
  parameter int ADDR_W = 32,
  parameter int COLL_W = 12,
  parameter int LEN_W  = 6
);
  // command side
  logic                     GO;
  logic [LEN_W-1:0]         BLOCK_LENGTH;
  logic [ADDR_W-1:0]        NEW_ADDR;
  logic [1:0]               NEW_SECTION;
  logic                     NEW_DIR;
  logic                     ACCEPT;
  logic                     READY;
  logic                     DONE;
  logic [ADDR_W-1:0]        OLD_ADDR;
  logic [LEN_W-1:0]         COUNT_SENT;
  logic                     ENDOF_PAGE;
  logic                     OVERRUN;
  // block mover side
  logic [COLL_W-1:0]        BLCK_START;
  logic [LEN_W-1:0]         BLCK_COUNT_REQ;
  logic [1:0]               BLCK_SECTION;
  logic                     BLCK_DIR;
  logic                     BLCK_ISSUE;
  logic [LEN_W-1:0]         BLCK_COUNT_SENT;
  logic                     BLCK_WORKING;
  // MCU page-align side
  logic [ADDR_W-COLL_W-1:0] MCU_PAGE_ADDR;
  logic                     MCU_REQUEST_ALIGN;
  logic                     MCU_GRANT_ALIGN;

  modport slave (
    input  GO, BLOCK_LENGTH, NEW_ADDR, NEW_SECTION, NEW_DIR,
    output ACCEPT, READY, DONE, OLD_ADDR, COUNT_SENT, ENDOF_PAGE, OVERRUN,
    output BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_DIR, BLCK_ISSUE,
    input  BLCK_COUNT_SENT, BLCK_WORKING,
    output MCU_PAGE_ADDR, MCU_REQUEST_ALIGN,
    input  MCU_GRANT_ALIGN
  );

  modport master (
    output GO, BLOCK_LENGTH, NEW_ADDR, NEW_SECTION, NEW_DIR,
    input  ACCEPT, READY, DONE, OLD_ADDR, COUNT_SENT, ENDOF_PAGE, OVERRUN,
    input  BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_DIR, BLCK_ISSUE,
    output BLCK_COUNT_SENT, BLCK_WORKING,
    input  MCU_PAGE_ADDR, MCU_REQUEST_ALIGN,
    output MCU_GRANT_ALIGN
  );
endinterface
`default_nettype wire

// File: rtl/hyper_lsab_dram_q.sv
`default_nettype none
// ============================================================================
// Module   : hyper_lsab_dram_q
// Purpose  : Command queue and sequencer moving word blocks between the LSAB
//            and DRAM. Commands are buffered in a QDEPTH-deep FIFO; each one
//            aligns the MCU to its DRAM page (skipped on a page hit), issues
//            one block-mover command limited to the page end, waits for the
//            mover to finish and reports the words actually moved.
// Ports    : CLK - clock, all logic on posedge
//            RST - asynchronous active-low reset
//            bus - hyper_lsab_dram_q_if.slave (command, result, mover, MCU)
// Config   : HYPER_LSAB_PAGE_SPLIT_EN - when defined, a block that crosses a
//            page end continues as a second segment at column 0 of the next
//            page; when undefined it is truncated at the page end.
// Revision : 1.0 - initial release
// ============================================================================
module hyper_lsab_dram_q #(
  parameter int ADDR_W = 32,
  parameter int COLL_W = 12,
  parameter int LEN_W  = 6,
  parameter int QDEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  hyper_lsab_dram_q_if.slave  bus
);

  localparam int PAGE_W = ADDR_W - COLL_W;
  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  // wide enough to hold both a full page size and any block length
  localparam int CMP_W  = (LEN_W > COLL_W) ? (LEN_W + 1) : (COLL_W + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [1:0]        section;
    logic              dir;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ALIGN      = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_END   = 3'd4,
    S_FINISH     = 3'd5
  } state_t;

  // ---------------------------------------------------------------- FIFO ---
  cmd_t             mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // ------------------------------------------------------------ sequencer --
  state_t            state_q,      state_d;
  logic              page_valid_q, page_valid_d;
  logic [PAGE_W-1:0] last_page_q,  last_page_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] cur_addr_q,   cur_addr_d;
  logic [LEN_W-1:0]  rem_q,        rem_d;
  logic [LEN_W-1:0]  total_q,      total_d;
  logic [1:0]        section_q,    section_d;
  logic              dir_q,        dir_d;
  logic              more_q,       more_d;

  // ------------------------------------------------------ registered outputs
  logic              done_q,           done_d;
  logic [ADDR_W-1:0] old_addr_q,       old_addr_d;
  logic [LEN_W-1:0]  count_sent_q,     count_sent_d;
  logic              endof_page_q,     endof_page_d;
  logic              overrun_q,        overrun_d;
  logic [COLL_W-1:0] blck_start_q,     blck_start_d;
  logic [LEN_W-1:0]  blck_count_req_q, blck_count_req_d;
  logic [1:0]        blck_section_q,   blck_section_d;
  logic              blck_dir_q,       blck_dir_d;
  logic              blck_issue_q,     blck_issue_d;
  logic [PAGE_W-1:0] mcu_page_addr_q,  mcu_page_addr_d;
  logic              mcu_request_q,    mcu_request_d;

  // ------------------------------------------------------------ wires -----
  logic              w_full;
  logic              w_pop;
  logic              w_accept;
  logic              w_push;
  cmd_t              w_cmd_in;
  cmd_t              w_head;
  logic [PAGE_W-1:0] w_cur_page;
  logic [COLL_W-1:0] w_cur_col;
  logic [CMP_W-1:0]  w_page_room;
  logic [LEN_W-1:0]  w_seg_len;
  logic [LEN_W-1:0]  w_sent;
  logic [LEN_W-1:0]  w_new_total;
  logic [ADDR_W-1:0] w_seg_next_addr;
  logic [ADDR_W-1:0] w_fin_addr;
  logic              w_split;

  assign w_full   = (count_q == CNT_W'(QDEPTH));
  // The head leaves the queue on the last FINISH cycle of a command.
  assign w_pop    = (state_q == S_FINISH) && !more_q;
  // A pop in the same cycle frees a slot, so a full queue still takes GO.
  assign w_accept = !w_full || w_pop;
  assign w_push   = bus.GO && w_accept;

  assign w_cmd_in.addr    = bus.NEW_ADDR;
  assign w_cmd_in.len     = bus.BLOCK_LENGTH;
  assign w_cmd_in.section = bus.NEW_SECTION;
  assign w_cmd_in.dir     = bus.NEW_DIR;
  assign w_head           = mem_q[rd_ptr_q];

  assign w_cur_page  = cur_addr_q[ADDR_W-1:COLL_W];
  assign w_cur_col   = cur_addr_q[COLL_W-1:0];
  // words left before the end of the current DRAM page
  assign w_page_room = (CMP_W'(1) << COLL_W) - CMP_W'(w_cur_col);
  assign w_seg_len   = (CMP_W'(rem_q) <= w_page_room) ? rem_q
                                                      : w_page_room[LEN_W-1:0];

  assign w_sent          = bus.BLCK_COUNT_SENT;
  assign w_new_total     = total_q + w_sent;
  assign w_seg_next_addr = cur_addr_q + ADDR_W'(w_sent);
  assign w_fin_addr      = start_addr_q + ADDR_W'(w_new_total);

`ifdef HYPER_LSAB_PAGE_SPLIT_EN
  // Continue only when the mover delivered the whole segment and the segment
  // was cut short by the page end; an early mover stop ends the command.
  assign w_split = (w_sent == blck_count_req_q) && (rem_q > blck_count_req_q);
`else
  assign w_split = 1'b0;
`endif

  // ------------------------------------------------------ FIFO pointers ---
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ------------------------------------------------ next-state / outputs --
  always_comb begin
    state_d          = state_q;
    page_valid_d     = page_valid_q;
    last_page_d      = last_page_q;
    start_addr_d     = start_addr_q;
    cur_addr_d       = cur_addr_q;
    rem_d            = rem_q;
    total_d          = total_q;
    section_d        = section_q;
    dir_d            = dir_q;
    more_d           = more_q;
    done_d           = 1'b0;
    old_addr_d       = old_addr_q;
    count_sent_d     = count_sent_q;
    endof_page_d     = endof_page_q;
    overrun_d        = overrun_q | (bus.GO & ~w_accept);
    blck_start_d     = blck_start_q;
    blck_count_req_d = blck_count_req_q;
    blck_section_d   = blck_section_q;
    blck_dir_d       = blck_dir_q;
    blck_issue_d     = 1'b0;
    mcu_page_addr_d  = mcu_page_addr_q;
    mcu_request_d    = mcu_request_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          start_addr_d = w_head.addr;
          cur_addr_d   = w_head.addr;
          rem_d        = w_head.len;
          total_d      = '0;
          section_d    = w_head.section;
          dir_d        = w_head.dir;
          more_d       = 1'b0;
          if (w_head.len == '0) begin
            // empty block: report immediately, leave the MCU and mover alone
            count_sent_d = '0;
            old_addr_d   = w_head.addr;
            endof_page_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_FINISH;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end

      S_ALIGN: begin
        if (!mcu_request_q) begin
          if (page_valid_q && (last_page_q == w_cur_page)) begin
            state_d          = S_ISSUE;
            blck_issue_d     = 1'b1;
            blck_start_d     = w_cur_col;
            blck_count_req_d = w_seg_len;
            blck_section_d   = section_q;
            blck_dir_d       = dir_q;
          end else begin
            mcu_request_d   = 1'b1;
            mcu_page_addr_d = w_cur_page;
          end
        end else if (bus.MCU_GRANT_ALIGN) begin
          mcu_request_d    = 1'b0;
          page_valid_d     = 1'b1;
          last_page_d      = w_cur_page;
          state_d          = S_ISSUE;
          blck_issue_d     = 1'b1;
          blck_start_d     = w_cur_col;
          blck_count_req_d = w_seg_len;
          blck_section_d   = section_q;
          blck_dir_d       = dir_q;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (bus.BLCK_WORKING) state_d = S_WAIT_END;
      end

      S_WAIT_END: begin
        if (!bus.BLCK_WORKING) begin
          total_d = w_new_total;
          state_d = S_FINISH;
          if (w_split) begin
            cur_addr_d = w_seg_next_addr;
            rem_d      = rem_q - w_sent;
            more_d     = 1'b1;
          end else begin
            more_d       = 1'b0;
            count_sent_d = w_new_total;
            old_addr_d   = w_fin_addr;
            endof_page_d = (w_fin_addr[COLL_W-1:0] == '0) && (w_new_total != '0);
            done_d       = 1'b1;
          end
        end
      end

      S_FINISH: begin
        if (more_q) begin
          // end of a segment only: next segment starts at column 0
          more_d  = 1'b0;
          state_d = S_ALIGN;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- registers ---
  always_ff @(posedge CLK) begin
    if (w_push) mem_q[wr_ptr_q] <= w_cmd_in;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      state_q          <= S_IDLE;
      page_valid_q     <= 1'b0;
      last_page_q      <= '0;
      start_addr_q     <= '0;
      cur_addr_q       <= '0;
      rem_q            <= '0;
      total_q          <= '0;
      section_q        <= '0;
      dir_q            <= 1'b0;
      more_q           <= 1'b0;
      done_q           <= 1'b0;
      old_addr_q       <= '0;
      count_sent_q     <= '0;
      endof_page_q     <= 1'b0;
      overrun_q        <= 1'b0;
      blck_start_q     <= '0;
      blck_count_req_q <= '0;
      blck_section_q   <= '0;
      blck_dir_q       <= 1'b0;
      blck_issue_q     <= 1'b0;
      mcu_page_addr_q  <= '0;
      mcu_request_q    <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      state_q          <= state_d;
      page_valid_q     <= page_valid_d;
      last_page_q      <= last_page_d;
      start_addr_q     <= start_addr_d;
      cur_addr_q       <= cur_addr_d;
      rem_q            <= rem_d;
      total_q          <= total_d;
      section_q        <= section_d;
      dir_q            <= dir_d;
      more_q           <= more_d;
      done_q           <= done_d;
      old_addr_q       <= old_addr_d;
      count_sent_q     <= count_sent_d;
      endof_page_q     <= endof_page_d;
      overrun_q        <= overrun_d;
      blck_start_q     <= blck_start_d;
      blck_count_req_q <= blck_count_req_d;
      blck_section_q   <= blck_section_d;
      blck_dir_q       <= blck_dir_d;
      blck_issue_q     <= blck_issue_d;
      mcu_page_addr_q  <= mcu_page_addr_d;
      mcu_request_q    <= mcu_request_d;
    end
  end

  // ------------------------------------------------------------ outputs ---
  assign bus.ACCEPT            = w_accept;
  assign bus.READY             = (count_q == '0) && (state_q == S_IDLE);
  assign bus.DONE              = done_q;
  assign bus.OLD_ADDR          = old_addr_q;
  assign bus.COUNT_SENT        = count_sent_q;
  assign bus.ENDOF_PAGE        = endof_page_q;
  assign bus.OVERRUN           = overrun_q;
  assign bus.BLCK_START        = blck_start_q;
  assign bus.BLCK_COUNT_REQ    = blck_count_req_q;
  assign bus.BLCK_SECTION      = blck_section_q;
  assign bus.BLCK_DIR          = blck_dir_q;
  assign bus.BLCK_ISSUE        = blck_issue_q;
  assign bus.MCU_PAGE_ADDR     = mcu_page_addr_q;
  assign bus.MCU_REQUEST_ALIGN = mcu_request_q;

endmodule
`default_nettype wire

// File: tb/tb_hyper_lsab_dram_q.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyper_lsab_dram_q
// Purpose  : Self-checking bench for hyper_lsab_dram_q. A responder process
//            plays the MCU (grants one cycle after a request) and the block
//            mover (busy for a few cycles, returns min(request, limit)).
//            Directed vectors come from a table; overrun and reset-in-flight
//            corner cases are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyper_lsab_dram_q;
  localparam int ADDR_W = 32;
  localparam int COLL_W = 12;
  localparam int LEN_W  = 6;
  localparam int QDEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  hyper_lsab_dram_q_if #(.ADDR_W(ADDR_W), .COLL_W(COLL_W), .LEN_W(LEN_W)) bus ();

  hyper_lsab_dram_q #(
    .ADDR_W(ADDR_W), .COLL_W(COLL_W), .LEN_W(LEN_W), .QDEPTH(QDEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  len;
    logic [1:0]  sec;
    int          limit;      // mover stops after this many words
    int          exp_req;    // BLCK_COUNT_REQ of first issue
    int          exp_cnt;
    logic [31:0] exp_old;
    logic        exp_eop;
    int          exp_aligns;
    int          exp_issues;
    int          exp_apage;  // first aligned page
    int          lat_kind;   // 0 none, 1 issue exactly 3 cycles, 2 done within 3
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // responder bookkeeping (written only by the responder)
  int          cyc       = 0;
  int          issue_cnt = 0;
  int          align_cnt = 0;
  int          done_cnt  = 0;
  int          issue_req [256];
  int          issue_cyc [256];
  logic [1:0]  issue_sec [256];
  int          align_page[256];
  logic [31:0] done_old  [256];
  int          done_num  [256];
  logic        done_eop  [256];
  int          done_cyc  [256];
  int          mv_state  = 0;
  int          mv_cnt    = 0;
  int          mv_req    = 0;

  // responder controls (written only by the main sequence)
  int mover_limit = 63;
  bit mover_hold  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------ MCU + mover responder --
  initial begin
    bus.BLCK_WORKING    = 1'b0;
    bus.BLCK_COUNT_SENT = '0;
    bus.MCU_GRANT_ALIGN = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (!RST) begin
        mv_state            = 0;
        bus.BLCK_WORKING    = 1'b0;
        bus.MCU_GRANT_ALIGN = 1'b0;
      end else begin
        if (bus.DONE) begin
          done_old[done_cnt & 255] = bus.OLD_ADDR;
          done_num[done_cnt & 255] = int'(bus.COUNT_SENT);
          done_eop[done_cnt & 255] = bus.ENDOF_PAGE;
          done_cyc[done_cnt & 255] = cyc;
          done_cnt++;
        end
        if (bus.MCU_REQUEST_ALIGN && !bus.MCU_GRANT_ALIGN) begin
          bus.MCU_GRANT_ALIGN = 1'b1;
          align_page[align_cnt & 255] = int'(bus.MCU_PAGE_ADDR);
          align_cnt++;
        end else begin
          bus.MCU_GRANT_ALIGN = 1'b0;
        end
        if (bus.BLCK_ISSUE) begin
          issue_req[issue_cnt & 255] = int'(bus.BLCK_COUNT_REQ);
          issue_cyc[issue_cnt & 255] = cyc;
          issue_sec[issue_cnt & 255] = bus.BLCK_SECTION;
          issue_cnt++;
          mv_req   = int'(bus.BLCK_COUNT_REQ);
          mv_state = 1;
        end else if (mv_state == 1) begin
          bus.BLCK_WORKING = 1'b1;
          mv_cnt   = 2;
          mv_state = 2;
        end else if (mv_state == 2 && !mover_hold) begin
          if (mv_cnt == 0) begin
            bus.BLCK_WORKING    = 1'b0;
            bus.BLCK_COUNT_SENT = LEN_W'((mv_req < mover_limit) ? mv_req : mover_limit);
            mv_state = 0;
          end else begin
            mv_cnt--;
          end
        end
      end
    end
  end

  task automatic send_go(input logic [31:0] a, input logic [5:0] l,
                         input logic [1:0] s, output int gc);
    @(negedge CLK);
    bus.GO           = 1'b1;
    bus.NEW_ADDR     = a;
    bus.BLOCK_LENGTH = l;
    bus.NEW_SECTION  = s;
    bus.NEW_DIR      = s[0];
    gc = cyc;
    @(negedge CLK);
    bus.GO = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int bi, ba, bd, gc;
    bi = issue_cnt;
    ba = align_cnt;
    bd = done_cnt;
    mover_limit = v.limit;
    send_go(v.addr, v.len, v.sec, gc);
    for (int k = 0; k < 300 && done_cnt == bd; k++) @(negedge CLK);
    chk({tag, "_done_seen"}, 64'(done_cnt > bd), 64'd1);
    if (done_cnt > bd) begin
      chk({tag, "_count_sent"}, 64'(done_num[bd & 255]), 64'(v.exp_cnt));
      chk({tag, "_old_addr"},   64'(done_old[bd & 255]), 64'(v.exp_old));
      chk({tag, "_endof_page"}, 64'(done_eop[bd & 255]), 64'(v.exp_eop));
      if (v.lat_kind == 2)
        chk({tag, "_done_within_3"}, 64'((done_cyc[bd & 255] - gc) <= 3), 64'd1);
    end
    repeat (4) @(negedge CLK);
    chk({tag, "_done_pulses"}, 64'(done_cnt - bd),  64'd1);
    chk({tag, "_aligns"},      64'(align_cnt - ba), 64'(v.exp_aligns));
    chk({tag, "_issues"},      64'(issue_cnt - bi), 64'(v.exp_issues));
    if (v.exp_issues > 0 && issue_cnt > bi) begin
      chk({tag, "_count_req"}, 64'(issue_req[bi & 255]), 64'(v.exp_req));
      chk({tag, "_section"},   64'(issue_sec[bi & 255]), 64'(v.sec));
      if (v.lat_kind == 1)
        chk({tag, "_issue_latency"}, 64'(issue_cyc[bi & 255] - gc), 64'd3);
    end
    if (v.exp_aligns > 0 && align_cnt > ba)
      chk({tag, "_align_page"}, 64'(align_page[ba & 255]), 64'(v.exp_apage));
    chk({tag, "_ready"}, 64'(bus.READY), 64'd1);
  endtask

  vec_t vecs[9];
  logic acc_b[5];

  initial begin
    int bd, bi, gc;
    bus.GO = 1'b0; bus.NEW_ADDR = '0; bus.BLOCK_LENGTH = '0;
    bus.NEW_SECTION = '0; bus.NEW_DIR = 1'b0;

    //          addr          len sec lim req cnt  old           eop al is apage lat
    vecs[0] = '{32'h0000_1000, 16, 0, 63, 16, 16, 32'h0000_1010, 0, 1, 1, 1,       0};
    vecs[1] = '{32'h0000_1000, 16, 1, 63, 16, 16, 32'h0000_1010, 0, 0, 1, 0,       1};
`ifdef HYPER_LSAB_PAGE_SPLIT_EN
    vecs[2] = '{32'h0000_0FF8, 16, 2, 63,  8, 16, 32'h0000_1008, 0, 2, 2, 0,       0};
    vecs[3] = '{32'h0000_1020, 16, 3,  5, 16,  5, 32'h0000_1025, 0, 0, 1, 0,       0};
    vecs[8] = '{32'h0000_3FFE,  4, 0, 63,  2,  4, 32'h0000_4002, 0, 2, 2, 3,       0};
`else
    vecs[2] = '{32'h0000_0FF8, 16, 2, 63,  8,  8, 32'h0000_1000, 1, 1, 1, 0,       0};
    vecs[3] = '{32'h0000_1020, 16, 3,  5, 16,  5, 32'h0000_1025, 0, 1, 1, 1,       0};
    vecs[8] = '{32'h0000_3FFE,  4, 0, 63,  2,  2, 32'h0000_4000, 1, 1, 1, 3,       0};
`endif
    vecs[4] = '{32'h0000_2000,  0, 0, 63,  0,  0, 32'h0000_2000, 0, 0, 0, 0,       2};
    vecs[5] = '{32'h0000_1FC0, 63, 1, 63, 63, 63, 32'h0000_1FFF, 0, 0, 1, 0,       0};
    vecs[6] = '{32'h0000_1FC1, 63, 2, 63, 63, 63, 32'h0000_2000, 1, 0, 1, 0,       0};
    vecs[7] = '{32'hFFFF_FFFF,  1, 3, 63,  1,  1, 32'h0000_0000, 1, 1, 1, 'hFFFFF, 0};

    // -------- reset values
    repeat (3) @(negedge CLK);
    chk("rst_accept",     64'(bus.ACCEPT),            64'd1);
    chk("rst_ready",      64'(bus.READY),             64'd1);
    chk("rst_done",       64'(bus.DONE),              64'd0);
    chk("rst_overrun",    64'(bus.OVERRUN),           64'd0);
    chk("rst_issue",      64'(bus.BLCK_ISSUE),        64'd0);
    chk("rst_mcu_req",    64'(bus.MCU_REQUEST_ALIGN), 64'd0);
    chk("rst_count_sent", 64'(bus.COUNT_SENT),        64'd0);
    chk("rst_old_addr",   64'(bus.OLD_ADDR),          64'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // -------- table-driven vectors
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // -------- overrun: stalled FSM, five back-to-back GOs
    mover_hold = 1'b1;
    mover_limit = 63;
    bd = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      acc_b[i] = bus.ACCEPT;
      bus.GO           = 1'b1;
      bus.NEW_ADDR     = 32'h0000_5000 + 32'(i * 16);
      bus.BLOCK_LENGTH = 6'd4;
      bus.NEW_SECTION  = 2'd0;
      bus.NEW_DIR      = 1'b0;
    end
    @(negedge CLK);
    bus.GO = 1'b0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("ovr_accept_before_go%0d", i), 64'(acc_b[i]), (i < 4) ? 64'd1 : 64'd0);
    chk("ovr_accept_full", 64'(bus.ACCEPT),  64'd0);
    chk("ovr_overrun",     64'(bus.OVERRUN), 64'd1);
    chk("ovr_ready_busy",  64'(bus.READY),   64'd0);
    mover_hold = 1'b0;
    for (int k = 0; k < 500 && (done_cnt - bd) < 4; k++) @(negedge CLK);
    repeat (6) @(negedge CLK);
    chk("ovr_done_count", 64'(done_cnt - bd), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovr_done%0d_old_addr", i), 64'(done_old[(bd + i) & 255]),
          64'(32'h0000_5004 + 32'(i * 16)));
    chk("ovr_sticky", 64'(bus.OVERRUN), 64'd1);
    chk("ovr_ready",  64'(bus.READY),   64'd1);

    // -------- reset while the mover is busy (WAIT_END)
    mover_hold = 1'b1;
    bi = issue_cnt;
    send_go(32'h0000_6000, 6'd8, 2'd1, gc);
    for (int k = 0; k < 100 && issue_cnt == bi; k++) @(negedge CLK);
    chk("rmid_issued", 64'(issue_cnt - bi), 64'd1);
    repeat (4) @(negedge CLK);
    bd = done_cnt;
    RST = 1'b0;
    #1;
    chk("rmid_done",       64'(bus.DONE),              64'd0);
    chk("rmid_ready",      64'(bus.READY),             64'd1);
    chk("rmid_accept",     64'(bus.ACCEPT),            64'd1);
    chk("rmid_overrun",    64'(bus.OVERRUN),           64'd0);
    chk("rmid_mcu_req",    64'(bus.MCU_REQUEST_ALIGN), 64'd0);
    chk("rmid_count_sent", 64'(bus.COUNT_SENT),        64'd0);
    mover_hold = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    chk("rmid_no_done", 64'(done_cnt - bd), 64'd0);

    // page_valid was cleared by reset: same page must realign
    run_vec('{32'h0000_1000, 16, 2, 63, 16, 16, 32'h0000_1010, 0, 1, 1, 1, 0}, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
